// File: rtl/reduce_tree_pipe_pkg.sv
// Operation encodings and per-element helpers shared by the reduction tree levels.
// Elements are carried at MAX_W bits inside the helpers; callers size-cast to their own W (W <= MAX_W).
package reduce_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] wide_t;

  // Padding value that leaves the reduction unchanged: all-ones for AND-type ops, zero otherwise.
  function automatic wide_t op_identity(input logic [1:0] op, input int w);
    wide_t id;
    id = '0;
    if (op == OP_AND || op == OP_NAND) begin
      id = {MAX_W{1'b1}} >> (MAX_W - w);
    end
    return id;
  endfunction

  // NAND combines as AND inside the tree; the inversion is applied once at the root.
  function automatic wide_t op_combine(input logic [1:0] op, input wide_t a, input wide_t b);
    wide_t r;
    case (op)
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_level.sv
// One reduction tree level: combines PAIRS adjacent operand pairs, optionally registered (REG), 1 or 0 cycles.
// Registered: accepts when empty or when downstream drains this cycle; unregistered: ready passes straight through.
module reduce_level
  import reduce_pkg::*;
#(
  parameter int PAIRS = 1,
  parameter int W     = 8,
  parameter bit REG   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_vld,
  output logic                 up_rdy,
  input  logic [2*PAIRS*W-1:0] up_dat,
  input  logic [1:0]           up_op,
  output logic                 dn_vld,
  input  logic                 dn_rdy,
  output logic [PAIRS*W-1:0]   dn_dat,
  output logic [1:0]           dn_op
);

  logic [PAIRS*W-1:0] comb_dat;

  always_comb begin
    comb_dat = '0;
    for (int p = 0; p < PAIRS; p++) begin
      comb_dat[p*W +: W] = W'(op_combine(up_op,
                                         wide_t'(up_dat[(2*p)*W +: W]),
                                         wide_t'(up_dat[(2*p+1)*W +: W])));
    end
  end

  if (REG) begin : g_reg
    logic               vld_q, vld_d;
    logic [PAIRS*W-1:0] dat_q, dat_d;
    logic [1:0]         op_q,  op_d;
    logic               load;

    // Load on an empty stage or when the held beat leaves this cycle (pass-through).
    always_comb begin
      load  = !vld_q || dn_rdy;
      vld_d = vld_q;
      dat_d = dat_q;
      op_d  = op_q;
      if (load) begin
        vld_d = up_vld;
        dat_d = comb_dat;
        op_d  = up_op;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        op_q  <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
        op_q  <= op_d;
      end
    end

    assign up_rdy = load;
    assign dn_vld = vld_q;
    assign dn_dat = dat_q;
    assign dn_op  = op_q;
  end else begin : g_comb
    assign up_rdy = dn_rdy;
    assign dn_vld = up_vld;
    assign dn_dat = comb_dat;
    assign dn_op  = up_op;
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// N_IN-operand bitwise AND/OR/XOR/NAND reduction tree, latency popcount(STAGE_MASK) cycles.
// Valid/ready both sides; in_ready is combinational from out_ready and drops once every registered level is full.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int                        N_IN       = 4,
  parameter int                        W          = 8,
  parameter logic [$clog2(N_IN)-1:0]   STAGE_MASK = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [1:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            busy
);

  localparam int L  = $clog2(N_IN);
  localparam int NP = 1 << L;

  logic [W-1:0]        pad_dat;
  logic [NP*W-1:0]     leaf_dat;
  // Level k writes its NP>>(k+1) results at word offset NP - (NP>>k); the root is the last word.
  logic [(NP-1)*W-1:0] node_dat;
  logic [L:0]          stg_vld;
  logic [L:0]          stg_rdy;
  logic [1:0]          stg_op [0:L];
  logic [W-1:0]        root_dat;

  assign pad_dat = W'(op_identity(in_op, W));

  always_comb begin
    for (int j = 0; j < NP; j++) begin
      leaf_dat[j*W +: W] = pad_dat;
    end
    leaf_dat[N_IN*W-1:0] = in_data;
  end

  assign stg_vld[0] = in_valid;
  assign stg_op[0]  = in_op;
  assign stg_rdy[L] = out_ready;
  assign in_ready   = stg_rdy[0];

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int PAIRS   = NP >> (k + 1);
    localparam int OUT_OFF = (NP - (NP >> k)) * W;

    logic [2*PAIRS*W-1:0] up_dat;

    if (k == 0) begin : g_first
      assign up_dat = leaf_dat;
    end else begin : g_inner
      assign up_dat = node_dat[(NP - (NP >> (k - 1)))*W +: 2*PAIRS*W];
    end

    reduce_level #(
      .PAIRS (PAIRS),
      .W     (W),
      .REG   (STAGE_MASK[k])
    ) u_level (
      .clk    (clk),
      .rst_n  (rst_n),
      .up_vld (stg_vld[k]),
      .up_rdy (stg_rdy[k]),
      .up_dat (up_dat),
      .up_op  (stg_op[k]),
      .dn_vld (stg_vld[k+1]),
      .dn_rdy (stg_rdy[k+1]),
      .dn_dat (node_dat[OUT_OFF +: PAIRS*W]),
      .dn_op  (stg_op[k+1])
    );
  end

  assign root_dat  = node_dat[(NP-2)*W +: W];
  assign out_data  = (stg_op[L] == OP_NAND) ? ~root_dat : root_dat;
  assign out_valid = stg_vld[L];
  assign busy      = |(stg_vld[L:1] & STAGE_MASK);

endmodule

// File: doc/reduce_tree_pipe.md
# reduce_tree_pipe

Parametrised N-input bitwise reduction tree (AND/OR/XOR/NAND) with a selectable pipeline register at each tree level and a valid/ready handshake on both sides. It replaces fixed 4-input gate chains with fixed per-gate delays. Timing is set by which levels are registered, not by delay annotations. The block sits between any producer of N parallel W-bit operands and a consumer that may stall.

## Interface
- `N_IN`, 4: number of operands; must be ≥ 2.
- `W`, 8: width of each operand and of the result.
- `STAGE_MASK`, all ones (L bits): bit k set means tree level k is registered. L = clog2(N_IN); level 0 is nearest the input.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_data` input N_IN*W: operand j occupies bits [j*W +: W].
- `in_op` input 2: operation for this beat; 00 AND, 01 OR, 10 XOR, 11 NAND.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output W: bitwise reduction of all N_IN operands.
- `busy` output 1: any registered stage holds a valid beat.

## Operation
- Operands are padded to 2^L with the identity element: all-ones for AND and NAND, zero for OR and XOR.
- Each level combines adjacent pairs: 2^(L-k) values in, 2^(L-k-1) values out.
- `in_op` travels with its beat through every stage. NAND is AND followed by inversion at the output.
- Registered level k holds `v_k`, its data and op.
- `ready_k` = !`v_k` | `ready_(k+1)`. The last ready term is `out_ready`.
- `in_ready` = `ready_0` of the first registered level, or `out_ready` if none.
- `in_ready` is combinational from `out_ready`. This is accepted; there is no skid buffer.
- A level loads when `ready_k` is high. It takes `v_k` from the upstream valid and captures the upstream data.
- A level holds its data and `v_k` while `v_k` is set and `ready_(k+1)` is low.
- Unregistered levels are pure combinational pass-through.
- A beat is transferred when valid and ready are both high at a port. Beats are never dropped, duplicated or reordered.
- Simultaneous load and unload of a full stage is a pass-through: throughput is 1 beat per cycle with `out_ready` held high.
- Reset, including mid-stream: all `v_k` and stage data clear to 0, and any in-flight beats are discarded.
- Outputs at reset:
  - `out_valid` = 0 and `busy` = 0.
  - `out_data` = 0 when the last level is registered; otherwise it follows the combinational input.
  - `in_ready` = 1 after reset release.

## Timing
- Latency = popcount(`STAGE_MASK`) cycles from input acceptance to `out_valid`.
- `STAGE_MASK` = 0: fully combinational. `out_valid` = `in_valid` and `in_ready` = `out_ready` in the same cycle.
- Capacity = popcount(`STAGE_MASK`) beats. With `out_ready` low, `in_ready` falls once all registered stages are full.
- Changing `in_op` between consecutive beats has no penalty.
- `in_data` and `in_op` must be stable while `in_valid` is high and `in_ready` is low.

## Structure
- Package `reduce_pkg`:
  - op constants `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NAND` (2-bit);
  - function `op_identity(op, W)`;
  - function `op_combine(op, a, b)`.
- Sub-module `reduce_level`, parameters `PAIRS`, `W`, `REG`:
  - one tree level combining PAIRS pairs;
  - optional valid/data/op register with the ready rule above.
- Top: padding logic, generate loop over L `reduce_level` instances, NAND output inversion, `busy` OR of stage valids.

## Test plan
All scenarios use N_IN=4, W=8, STAGE_MASK=2'b11 unless stated.
- AND 0xFF,0x0F,0x3C,0xF0 → `out_data`=0x00 two cycles after acceptance. Same beat with OR → 0xFF; with NAND → 0xFF.
- N_IN=5: XOR 0x01,0x02,0x04,0x08,0x10 → 0x1F. AND of five 0xAA → 0xAA, which checks all-ones padding.
- Stream of 4 beats with alternating ops, `out_ready` high → results on 4 consecutive cycles, in order, latency 2.
- `out_ready` low 5 cycles during a 3-beat burst → `in_ready` drops after 2 accepted beats and `out_data` holds stable. On release all 3 results arrive in order, none lost.
- `rst_n` asserted with 2 beats in flight → `out_valid`, `busy` and data regs go to 0 immediately. After release, a new beat completes normally.
- STAGE_MASK=0 → `out_valid` equals `in_valid` in the same cycle, and the result matches the combinational reduction.
